// File: rtl/obi_mux_rr_n_to_1.sv
// rtl/obi_mux_rr_n_to_1.sv - N-to-1 OBI mux with round-robin arbitration and in-order response routing
// Define OBI_MUX_PRIO0_EN to give port 0 fixed priority over round-robin among ports 1..N-1.
module obi_mux_rr_n_to_1 #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_PORTS-1:0]              mgr_req_i,
  output logic [NUM_PORTS-1:0]              mgr_gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   mgr_addr_i,
  input  logic [NUM_PORTS-1:0]              mgr_we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] mgr_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   mgr_wdata_i,
  output logic [NUM_PORTS-1:0]              mgr_rvalid_o,
  output logic [DATA_WIDTH-1:0]             mgr_rdata_o,
  output logic                              shr_req_o,
  input  logic                              shr_gnt_i,
  output logic [ADDR_WIDTH-1:0]             shr_addr_o,
  output logic                              shr_we_o,
  output logic [DATA_WIDTH/8-1:0]           shr_be_o,
  output logic [DATA_WIDTH-1:0]             shr_wdata_o,
  input  logic                              shr_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             shr_rdata_i,
  output logic                              bad_state_o
);
  localparam int IDX_W = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = ($clog2(MAX_OUTSTANDING) > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock_valid;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_found;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [OCC_W-1:0] occ;
  logic             any_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             bad_state;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_PORTS - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : v + PTR_W'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping around the port list.
  always_comb begin
    rr_winner = '0;
    rr_found  = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = IDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!rr_found && mgr_req_i[scan_idx]) begin
        rr_winner = scan_idx;
        rr_found  = 1'b1;
      end
    end
  end

  // A stalled request keeps its port so the shared-side fields stay stable until granted.
  always_comb begin
    if (lock_valid) winner = lock_idx;
`ifdef OBI_MUX_PRIO0_EN
    else if (mgr_req_i[0]) winner = '0;
`endif
    else winner = rr_winner;
  end

  assign any_req     = |mgr_req_i;
  assign fifo_full   = (occ == OCC_W'(MAX_OUTSTANDING));
  assign fifo_empty  = (occ == '0);
  assign shr_req_o   = any_req & ~fifo_full;
  assign push        = shr_req_o & shr_gnt_i;
  assign pop         = shr_rvalid_i & ~fifo_empty;
  assign head_idx    = fifo_mem[head];
  assign mgr_rdata_o = shr_rdata_i;
  assign bad_state_o = bad_state;

  always_comb begin
    shr_addr_o   = '0;
    shr_we_o     = 1'b0;
    shr_be_o     = '0;
    shr_wdata_o  = '0;
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (any_req && winner == IDX_W'(k)) begin
        shr_addr_o   = mgr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        shr_we_o     = mgr_we_i[k];
        shr_be_o     = mgr_be_i[k*BE_W +: BE_W];
        shr_wdata_o  = mgr_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        mgr_gnt_o[k] = push;
      end
      if (pop && head_idx == IDX_W'(k)) mgr_rvalid_o[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[tail] <= winner;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      head       <= '0;
      tail       <= '0;
      occ        <= '0;
      bad_state  <= 1'b0;
    end else begin
      if (push) begin
        lock_valid <= 1'b0;
        tail       <= ptr_inc(tail);
`ifdef OBI_MUX_PRIO0_EN
        if (winner != '0) rr_ptr <= idx_inc(winner);
`else
        rr_ptr <= idx_inc(winner);
`endif
      end else if (shr_req_o) begin
        lock_valid <= 1'b1;
        lock_idx   <= winner;
      end
      if (pop) head <= ptr_inc(head);
      if (push && !pop) occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);
      // Sticky: a response with nothing outstanding means the subordinate and mux disagree.
      if (shr_rvalid_i && fifo_empty) bad_state <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_mux_rr_n_to_1.sv
// tb/tb_obi_mux_rr_n_to_1.sv - randomized scoreboard bench for obi_mux_rr_n_to_1
// Honours OBI_MUX_PRIO0_EN in its reference model when the macro is defined.
module tb_obi_mux_rr_n_to_1;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int MAX = 2;
`ifdef OBI_MUX_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    mgr_req_i = '0;
  logic [N-1:0]    mgr_gnt_o;
  logic [N*AW-1:0] mgr_addr_i = '0;
  logic [N-1:0]    mgr_we_i = '0;
  logic [N*BW-1:0] mgr_be_i = '0;
  logic [N*DW-1:0] mgr_wdata_i = '0;
  logic [N-1:0]    mgr_rvalid_o;
  logic [DW-1:0]   mgr_rdata_o;
  logic            shr_req_o;
  logic            shr_gnt_i = 1'b0;
  logic [AW-1:0]   shr_addr_o;
  logic            shr_we_o;
  logic [BW-1:0]   shr_be_o;
  logic [DW-1:0]   shr_wdata_o;
  logic            shr_rvalid_i = 1'b0;
  logic [DW-1:0]   shr_rdata_i = '0;
  logic            bad_state_o;

  obi_mux_rr_n_to_1 #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o),
    .shr_req_o(shr_req_o), .shr_gnt_i(shr_gnt_i), .shr_addr_o(shr_addr_o),
    .shr_we_o(shr_we_o), .shr_be_o(shr_be_o), .shr_wdata_o(shr_wdata_o),
    .shr_rvalid_i(shr_rvalid_i), .shr_rdata_i(shr_rdata_i), .bad_state_o(bad_state_o)
  );

  always #5 clk = ~clk;

  // Manager-side transaction fields, packed onto the buses every cycle.
  logic [AW-1:0] p_addr [N];
  logic          p_we   [N];
  logic [BW-1:0] p_be   [N];
  logic [DW-1:0] p_wdata[N];
  logic [DW-1:0] sub_rdata = '0;
  logic [N-1:0]  gnt_seen = '0;
  logic [N-1:0]  allowed = '1;
  int req_prob = 0, gnt_prob = 0, rsp_prob = 0;
  bit inject_spur = 1'b0;
  int sub_pending = 0;

  int n_checks = 0, n_errors = 0;
  bit check_en = 1'b0;

  // Reference model: rr pointer, held lock (-1 none), outstanding count, sticky error.
  int m_rr = 0, m_lock = -1, m_outst = 0, push_pend = -1;
  bit m_bad = 1'b0;
  int exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    if (m_lock >= 0) return m_lock;
    if (PRIO0 && mgr_req_i[0]) return 0;
    for (int i = 0; i < N; i++) begin
      if (mgr_req_i[(m_rr + i) % N]) return (m_rr + i) % N;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      int w;
      bit any_r, exp_req, hs;
      logic [N-1:0] eg;
      logic [AW+1+BW+DW-1:0] ef;
      any_r   = |mgr_req_i;
      w       = pick_winner();
      exp_req = any_r && (m_outst < MAX);
      hs      = exp_req && shr_gnt_i;
      ef      = any_r ? {p_addr[w], p_we[w], p_be[w], p_wdata[w]} : '0;
      eg      = '0;
      if (hs) eg[w] = 1'b1;
      chk("shr_req", 128'(shr_req_o), 128'(exp_req));
      chk("shr_fields", 128'({shr_addr_o, shr_we_o, shr_be_o, shr_wdata_o}), 128'(ef));
      chk("mgr_gnt", 128'(mgr_gnt_o), 128'(eg));
      chk("bad_state", 128'(bad_state_o), 128'(m_bad));
      if (hs) begin
        push_pend = w;
        m_lock    = -1;
        if (!(PRIO0 && w == 0)) m_rr = (w + 1) % N;
      end else if (exp_req) begin
        m_lock = w;
      end
      if (shr_rvalid_i) begin
        if (m_outst > 0) m_outst--;
        else m_bad = 1'b1;
      end
      if (hs) m_outst++;
    end
  end

  // Grants become visible to the response monitor only from the following cycle.
  always @(posedge clk) begin
    if (push_pend >= 0) begin
      exp_q.push_back(push_pend);
      push_pend = -1;
    end
    if (rst_i) begin
      m_rr = 0; m_lock = -1; m_outst = 0; m_bad = 1'b0; push_pend = -1;
      exp_q.delete();
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [N-1:0] er;
      int p;
      er = '0;
      if (shr_rvalid_i && exp_q.size() > 0) begin
        p = exp_q.pop_front();
        er[p] = 1'b1;
      end
      chk("mgr_rvalid", 128'(mgr_rvalid_o), 128'(er));
      if (|er) chk("mgr_rdata", 128'(mgr_rdata_o), 128'(sub_rdata));
    end
  end

  task automatic step();
    @(negedge clk);
    gnt_seen = mgr_gnt_o;
    if (shr_rvalid_i && sub_pending > 0) sub_pending--;
    if (shr_req_o && shr_gnt_i) sub_pending++;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (!(mgr_req_i[k] && !gnt_seen[k])) begin
        mgr_req_i[k] = allowed[k] && (int'($urandom_range(99)) < req_prob);
        p_addr[k]    = $urandom;
        p_we[k]      = 1'($urandom_range(1));
        p_be[k]      = BW'($urandom);
        p_wdata[k]   = $urandom;
      end
      mgr_addr_i[k*AW +: AW]  = p_addr[k];
      mgr_we_i[k]             = p_we[k];
      mgr_be_i[k*BW +: BW]    = p_be[k];
      mgr_wdata_i[k*DW +: DW] = p_wdata[k];
    end
    shr_gnt_i    = (int'($urandom_range(99)) < gnt_prob);
    shr_rvalid_i = inject_spur || (sub_pending > 0 && int'($urandom_range(99)) < rsp_prob);
    sub_rdata    = $urandom;
    shr_rdata_i  = sub_rdata;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    req_prob = 0; gnt_prob = 100; rsp_prob = 100;
    while ((sub_pending > 0 || (|mgr_req_i) || shr_rvalid_i) && t < budget) begin
      step();
      t++;
    end
    chk("drain_done", 128'(t < budget), 128'(1));
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      p_addr[k] = '0; p_we[k] = 1'b0; p_be[k] = '0; p_wdata[k] = '0;
    end
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    check_en = 1'b1;
    step();

    allowed = 4'b0100; req_prob = 100; gnt_prob = 100; rsp_prob = 100;
    repeat (6) step();
    allowed = 4'b1111;
    repeat (40) step();

    drain(100);
    allowed = 4'b1010; req_prob = 100; gnt_prob = 25; rsp_prob = 80;
    repeat (60) step();

    allowed = 4'b1111; req_prob = 100; gnt_prob = 100; rsp_prob = 15;
    repeat (80) step();

    allowed = 4'b0101; req_prob = 100; gnt_prob = 100; rsp_prob = 100;
    repeat (20) step();
    allowed = 4'b0100;
    repeat (10) step();

    for (int r = 0; r < 6; r++) begin
      allowed  = N'($urandom);
      req_prob = int'($urandom_range(20, 100));
      gnt_prob = int'($urandom_range(20, 100));
      rsp_prob = int'($urandom_range(10, 100));
      repeat (100) step();
    end

    drain(200);
    inject_spur = 1'b1;
    step();
    inject_spur = 1'b0;
    repeat (5) step();
    chk("bad_sticky", 128'(bad_state_o), 128'(1));
    rst_i = 1'b1;
    repeat (2) step();
    rst_i = 1'b0;
    step();
    chk("bad_cleared", 128'(bad_state_o), 128'(0));

    allowed = 4'b1111; req_prob = 80; gnt_prob = 70; rsp_prob = 20;
    repeat (30) step();
    rst_i = 1'b1; req_prob = 0;
    repeat (2) step();
    rst_i = 1'b0;
    drain(300);
    rst_i = 1'b1;
    repeat (2) step();
    rst_i = 1'b0;

    allowed = 4'b1111; req_prob = 60; gnt_prob = 60; rsp_prob = 50;
    repeat (200) step();
    drain(300);
    step();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
